// File: rtl/result_serializer.sv
// result_serializer
//   Captures a W-bit result on a load strobe and streams it out as N = W/DW
//   words of DW bits, least-significant word first, over a valid/ready
//   interface with an end-of-frame flag. A load offered while a frame is
//   still in flight is rejected and counted in a saturating 8-bit counter.
//   A load offered in the cycle the last word transfers is accepted and
//   starts the next frame with no bubble.
module result_serializer #(
  parameter int W  = 96,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [W-1:0]  y_in,
  output logic          ld_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic [7:0]    drop_cnt
);

  localparam int N  = W / DW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      drop_q, drop_d;

  logic            xfer;
  logic            at_last;
  logic            accept;
  logic            reject;

  // Saturating increment: the drop counter sticks at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  // The output word is always the low slice of the shift register; the
  // register only moves on a transfer, so dout is stable under backpressure.
  assign dout_valid = (state_q == SEND);
  assign at_last    = (idx_q == LAST_IDX);
  assign xfer       = dout_valid & dout_ready;
  assign dout_last  = at_last & dout_valid;
  assign dout       = shreg_q[DW-1:0];
  assign drop_cnt   = drop_q;

  // Ready when idle, or when the final word of the current frame is leaving
  // this cycle so the next frame can follow back-to-back.
  assign ld_ready   = (state_q == IDLE) | (xfer & at_last);
  assign accept     = ld & ld_ready;
  assign reject     = ld & ~ld_ready;

  // Next-state, shift register and word index.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = y_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (at_last) begin
            if (accept) begin
              shreg_d = y_in;
              idx_d   = '0;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_q >> DW;
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drop counter: a rejected load never touches the frame in flight.
  always_comb begin
    drop_d = drop_q;
    if (reject) begin
      drop_d = sat_inc8(drop_q);
    end
  end

  // State registers; reset wins over a load or transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer
//   Table-driven bench for result_serializer: each table row is one clock
//   cycle of inputs plus the outputs expected during that cycle. Inputs are
//   driven on the falling edge and outputs sampled 1ns later, away from the
//   rising edge. Long and randomised corner cases are written by hand.
module tb_result_serializer;

  localparam int W  = 96;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld;
  logic [W-1:0]  y_in;
  logic          ld_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic [7:0]    drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  result_serializer #(.W(W), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld),
    .y_in       (y_in),
    .ld_ready   (ld_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic        ld;
    logic        rdy;
    logic [95:0] y;
    bit          chk;
    bit          dchk;
    logic [31:0] dout;
    logic        vld;
    logic        last;
    logic        ldr;
    logic [7:0]  drop;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic l, input logic d,
                              input logic [95:0] y, input bit c, input bit dc,
                              input logic [31:0] o, input logic v,
                              input logic la, input logic lr,
                              input logic [7:0] dr);
    vec_t t;
    t.rst = r; t.ld = l; t.rdy = d; t.y = y; t.chk = c; t.dchk = dc;
    t.dout = o; t.vld = v; t.last = la; t.ldr = lr; t.drop = dr;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic apply_row(input int i);
    vec_t t;
    t = tbl[i];
    @(negedge clk);
    rst = t.rst; ld = t.ld; dout_ready = t.rdy; y_in = t.y;
    #1;
    if (t.chk) begin
      if (t.dchk) chk("dout", i, 96'(dout), 96'(t.dout));
      chk("dout_valid", i, 96'(dout_valid), 96'(t.vld));
      chk("dout_last",  i, 96'(dout_last),  96'(t.last));
      chk("ld_ready",   i, 96'(ld_ready),   96'(t.ldr));
      chk("drop_cnt",   i, 96'(drop_cnt),   96'(t.drop));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [95:0] ya, yb, yc, yd, ye, yf, y1, exp_y, got;
    logic [31:0] x;
    int p1_end, words, budget;

    y1 = 96'h00000003_00000002_00000001;
    ya = 96'h000000A3_000000A2_000000A1;
    yb = 96'h000000B3_000000B2_000000B1;
    yc = 96'h00000C03_00000C02_00000C01;
    yd = 96'h00000D03_00000D02_00000D01;
    ye = 96'h00000E03_00000E02_00000E01;
    yf = 96'h00000F03_00000F02_00000F01;

    rst = 1'b1; ld = 1'b0; dout_ready = 1'b0; y_in = '0;

    // Reset and basic frame
    add(1,0,0,'0, 0,0,0,        0,0,0,0);
    add(1,0,0,'0, 1,1,0,        0,0,1,0);
    add(0,1,1,y1, 1,0,0,        0,0,1,0);
    add(0,0,1,'0, 1,1,32'h1,    1,0,0,0);
    add(0,0,1,'0, 1,1,32'h2,    1,0,0,0);
    add(0,0,1,'0, 1,1,32'h3,    1,1,1,0);
    add(0,0,1,'0, 1,0,0,        0,0,1,0);
    // Backpressure on word 2
    add(0,1,1,y1, 1,0,0,        0,0,1,0);
    add(0,0,1,'0, 1,1,32'h1,    1,0,0,0);
    add(0,0,0,'0, 1,1,32'h2,    1,0,0,0);
    add(0,0,0,'0, 1,1,32'h2,    1,0,0,0);
    add(0,0,0,'0, 1,1,32'h2,    1,0,0,0);
    add(0,0,1,'0, 1,1,32'h2,    1,0,0,0);
    add(0,0,1,'0, 1,1,32'h3,    1,1,1,0);
    add(0,0,1,'0, 1,0,0,        0,0,1,0);
    // Back-to-back frames A then B
    add(0,1,1,ya, 1,0,0,        0,0,1,0);
    add(0,0,1,'0, 1,1,32'hA1,   1,0,0,0);
    add(0,0,1,'0, 1,1,32'hA2,   1,0,0,0);
    add(0,1,1,yb, 1,1,32'hA3,   1,1,1,0);
    add(0,0,1,'0, 1,1,32'hB1,   1,0,0,0);
    add(0,0,1,'0, 1,1,32'hB2,   1,0,0,0);
    add(0,0,1,'0, 1,1,32'hB3,   1,1,1,0);
    add(0,0,1,'0, 1,0,0,        0,0,1,0);
    // Dropped load during word 0
    add(0,1,1,yc, 1,0,0,        0,0,1,0);
    add(0,1,1,{3{32'hFFFFFFFF}}, 1,1,32'hC01, 1,0,0,0);
    add(0,0,1,'0, 1,1,32'hC02,  1,0,0,1);
    add(0,0,1,'0, 1,1,32'hC03,  1,1,1,1);
    add(0,0,1,'0, 1,0,0,        0,0,1,1);
    p1_end = tbl.size();
    // Reset mid-frame (drop_cnt is saturated when this runs)
    add(0,1,1,ye, 1,0,0,        0,0,1,8'd255);
    add(0,0,1,'0, 1,1,32'hE01,  1,0,0,8'd255);
    add(0,0,1,'0, 1,1,32'hE02,  1,0,0,8'd255);
    add(1,0,0,'0, 1,1,32'hE03,  1,1,0,8'd255);
    add(0,1,1,yf, 1,1,0,        0,0,1,0);
    add(0,0,1,'0, 1,1,32'hF01,  1,0,0,0);
    add(0,0,1,'0, 1,1,32'hF02,  1,0,0,0);
    add(0,0,1,'0, 1,1,32'hF03,  1,1,1,0);
    add(0,0,1,'0, 1,0,0,        0,0,1,0);

    for (int i = 0; i < p1_end; i++) apply_row(i);

    // Saturation: hold a frame under backpressure while loads keep arriving
    @(negedge clk);
    rst = 1'b0; ld = 1'b1; dout_ready = 1'b1; y_in = yd;
    #1;
    chk("sat_ld_ready", -1, 96'(ld_ready), 96'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ld = 1'b1; dout_ready = 1'b0; y_in = {$urandom, $urandom, $urandom};
      #1;
      if (i == 0 || i == 254 || i == 299) begin
        chk("sat_drop_cnt", i, 96'(drop_cnt), (i == 0) ? 96'd1 : 96'd255);
        chk("sat_dout",     i, 96'(dout),      96'h0D01);
        chk("sat_valid",    i, 96'(dout_valid), 96'd1);
        chk("sat_last",     i, 96'(dout_last),  96'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ld = 1'b0; dout_ready = 1'b1;
      #1;
      chk("sat_tail_drop", i, 96'(drop_cnt), 96'd255);
      chk("sat_tail_dout", i, 96'(dout), 96'(yd[i*32 +: 32]));
      chk("sat_tail_last", i, 96'(dout_last), (i == 2) ? 96'd1 : 96'd0);
    end

    for (int i = p1_end; i < tbl.size(); i++) apply_row(i);

    // Upstream integration: random results, random consumer stalls
    for (int f = 0; f < 8; f++) begin
      @(negedge clk);
      x = $urandom;
      rst = 1'b0; ld = 1'b1; dout_ready = 1'b1;
      y_in = {x + 32'd7, ~x, x ^ 32'hDEADBEEF};
      #1;
      exp_y = y_in;
      chk("int_ld_ready", f, 96'(ld_ready), 96'd1);
      got = '0;
      words = 0;
      budget = 40;
      while (words < 3 && budget > 0) begin
        @(negedge clk);
        ld = 1'b0; dout_ready = 1'($urandom_range(0, 1));
        y_in = {$urandom, $urandom, $urandom};
        #1;
        if (dout_valid && dout_ready) begin
          got[words*32 +: 32] = dout;
          chk("int_last", f, 96'(dout_last), (words == 2) ? 96'd1 : 96'd0);
          words++;
        end
        budget--;
      end
      chk("int_words", f, 96'(words), 96'd3);
      chk("int_frame", f, got, exp_y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
